// File: rtl/sci_notation_seq.sv
// Sequential scientific-notation converter: divides the operand by 10 once per
// clock until it fits the mantissa range, with optional round-half-up and saturation.
module sci_notation_seq #(
  parameter int unsigned IN_W     = 30,
  parameter int unsigned MANT_MAX = 1000,
  parameter int unsigned EXP_W    = 4,
  parameter int unsigned EXP_MAX  = 8,
  parameter int unsigned ROUND_EN = 1,
  localparam int unsigned MANT_W  = $clog2(MANT_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   value,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] mantissa,
  output logic [EXP_W-1:0]  exponent,
  output logic              overflow
);

  localparam logic [IN_W-1:0]   MANT_MAX_W = IN_W'(MANT_MAX);
  localparam logic [IN_W-1:0]   TEN_W      = IN_W'(10);
  localparam logic [MANT_W:0]   MANT_MAX_M = (MANT_W+1)'(MANT_MAX);
  localparam logic [MANT_W:0]   MANT_TEN_M = (MANT_W+1)'(MANT_MAX / 10);
  localparam logic [MANT_W-1:0] MANT_SAT   = MANT_W'(MANT_MAX - 1);
  localparam logic [EXP_W-1:0]  EXP_MAX_E  = EXP_W'(EXP_MAX);
  localparam logic [EXP_W:0]    EXP_MAX_X  = (EXP_W+1)'(EXP_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IN_W-1:0]     work_r, work_s;
  logic [EXP_W-1:0]    exp_r, exp_s;
  logic [3:0]          rem_r, rem_s;
  logic                busy_s, done_s, ovf_s;
  logic [MANT_W-1:0]   mant_s;
  logic [EXP_W-1:0]    expo_s;
  logic [MANT_W:0]     m_rnd_s, m_fin_s;
  logic [EXP_W:0]      e_fin_s;

  // Only the single last discarded digit decides rounding (no sticky bits).
  function automatic logic round_up(input logic [3:0] digit);
    round_up = (ROUND_EN != 0) && (digit >= 4'd5);
  endfunction

  // Next-state, datapath and result computation.
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    exp_s   = exp_r;
    rem_s   = rem_r;
    busy_s  = busy;
    done_s  = 1'b0;
    mant_s  = mantissa;
    expo_s  = exponent;
    ovf_s   = overflow;

    m_rnd_s = {1'b0, work_r[MANT_W-1:0]} + {{MANT_W{1'b0}}, round_up(rem_r)};
    if (m_rnd_s == MANT_MAX_M) begin
      m_fin_s = MANT_TEN_M;
      e_fin_s = {1'b0, exp_r} + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      m_fin_s = m_rnd_s;
      e_fin_s = {1'b0, exp_r};
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
          work_s  = value;
          exp_s   = {EXP_W{1'b0}};
          rem_s   = 4'd0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (work_r < MANT_MAX_W) begin
          state_s = ST_ROUND;
        end else if (exp_r == EXP_MAX_E) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          mant_s  = MANT_SAT;
          expo_s  = EXP_MAX_E;
          ovf_s   = 1'b1;
        end else begin
          work_s  = work_r / TEN_W;
          rem_s   = 4'(work_r % TEN_W);
          exp_s   = exp_r + EXP_W'(1);
        end
      end
      ST_ROUND: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
        // Rounding up to MANT_MAX can push the exponent past its limit.
        if (e_fin_s > EXP_MAX_X) begin
          mant_s = MANT_SAT;
          expo_s = EXP_MAX_E;
          ovf_s  = 1'b1;
        end else begin
          mant_s = m_fin_s[MANT_W-1:0];
          expo_s = e_fin_s[EXP_W-1:0];
          ovf_s  = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      work_r   <= {IN_W{1'b0}};
      exp_r    <= {EXP_W{1'b0}};
      rem_r    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mantissa <= {MANT_W{1'b0}};
      exponent <= {EXP_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      state_r  <= state_s;
      work_r   <= work_s;
      exp_r    <= exp_s;
      rem_r    <= rem_s;
      busy     <= busy_s;
      done     <= done_s;
      mantissa <= mant_s;
      exponent <= expo_s;
      overflow <= ovf_s;
    end
  end

endmodule

// File: tb/tb_sci_notation_seq.sv
// Directed self-checking bench for sci_notation_seq: defaults, truncation and
// a reduced EXP_MAX instance, plus handshake and reset-abort scenarios.
module tb_sci_notation_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] value;
  logic        start [3];
  logic        busy  [3];
  logic        done  [3];
  logic [9:0]  mant  [3];
  logic [3:0]  expo  [3];
  logic        ovf   [3];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: truncation, 2: EXP_MAX=5.
  sci_notation_seq u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .value(value),
    .busy(busy[0]), .done(done[0]), .mantissa(mant[0]), .exponent(expo[0]), .overflow(ovf[0])
  );
  sci_notation_seq #(.ROUND_EN(0)) u_nr (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .value(value),
    .busy(busy[1]), .done(done[1]), .mantissa(mant[1]), .exponent(expo[1]), .overflow(ovf[1])
  );
  sci_notation_seq #(.EXP_MAX(5)) u_em5 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .value(value),
    .busy(busy[2]), .done(done[2]), .mantissa(mant[2]), .exponent(expo[2]), .overflow(ovf[2])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int idx, input logic [29:0] v);
    value      = v;
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int base, output int edges);
    edges = base;
    while (done[idx] !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_res(input string tag, input int idx, input int em, input int ee, input int eo);
    check_val({tag, "_done"}, 32'(done[idx]), 32'd1);
    check_val({tag, "_busy0"}, 32'(busy[idx]), 32'd0);
    check_val({tag, "_mant"}, 32'(mant[idx]), em);
    check_val({tag, "_exp"}, 32'(expo[idx]), ee);
    check_val({tag, "_ovf"}, 32'(ovf[idx]), eo);
  endtask

  task automatic convert(input string tag, input int idx, input logic [29:0] v,
                         input int em, input int ee, input int eo, input int elat, input bit sync);
    int edges;
    if (sync) @(negedge clk);
    launch(idx, v);
    check_val({tag, "_busy1"}, 32'(busy[idx]), 32'd1);
    wait_done(idx, 0, edges);
    check_val({tag, "_lat"}, edges, elat);
    check_res(tag, idx, em, ee, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int seen;
    rst_n = 1'b0;
    value = 30'd0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    #12;
    check_val("rst_mant", 32'(mant[0]), 32'd0);
    check_val("rst_exp", 32'(expo[0]), 32'd0);
    check_val("rst_ovf", 32'(ovf[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert("d7", 0, 30'd7, 7, 0, 0, 2, 1'b1);
    @(posedge clk);
    #1;
    check_val("d7_pulse", 32'(done[0]), 32'd0);
    check_val("d7_hold", 32'(mant[0]), 32'd7);

    convert("d123456", 0, 30'd123456, 123, 3, 0, 5, 1'b1);
    convert("d999500", 0, 30'd999500, 100, 4, 0, 5, 1'b1);
    convert("d0", 0, 30'd0, 0, 0, 0, 2, 1'b1);
    convert("d999", 0, 30'd999, 999, 0, 0, 2, 1'b1);
    convert("d1000", 0, 30'd1000, 100, 1, 0, 3, 1'b1);
    convert("d9995", 0, 30'd9995, 100, 2, 0, 3, 1'b1);
    convert("dmax", 0, 30'h3FFF_FFFF, 107, 7, 0, 9, 1'b1);
    convert("nr999500", 1, 30'd999500, 999, 3, 0, 5, 1'b1);
    convert("e5max", 2, 30'h3FFF_FFFF, 999, 5, 1, 6, 1'b1);
    convert("e5rndsat", 2, 30'd99950000, 999, 5, 1, 7, 1'b1);
    convert("e5edge", 2, 30'd99949999, 999, 5, 0, 7, 1'b1);

    // Back-to-back: second start raised in the done cycle.
    convert("b2b_a", 0, 30'd7, 7, 0, 0, 2, 1'b1);
    convert("b2b_b", 0, 30'd123456, 123, 3, 0, 5, 1'b0);

    // start and value changes while busy are ignored.
    @(negedge clk);
    launch(0, 30'd123456);
    @(negedge clk);
    value    = 30'd7;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    value    = 30'd999500;
    wait_done(0, 1, edges);
    check_val("mid_lat", edges, 5);
    check_res("mid", 0, 123, 3, 0);

    // Reset mid-SHIFT aborts without a done pulse.
    @(negedge clk);
    launch(0, 30'd123456);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_mant", 32'(mant[0]), 32'd0);
    check_val("abort_exp", 32'(expo[0]), 32'd0);
    check_val("abort_busy", 32'(busy[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done[0] === 1'b1) seen++;
    end
    check_val("abort_nodone", seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    convert("post_rst", 0, 30'd999500, 100, 4, 0, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
